// File: rtl/genome_pkg.sv
// Shared definitions for the packed-nucleotide decode path.
// Contents: 2-bit base codes, their ASCII bytes, and the sequencer state encoding.
// No logic; imported by the decode cell and the sequencer.
package genome_pkg;

    // 2-bit packed base codes
    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;

    // ASCII representation of each base
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_G = 8'h47;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/TwoBit2Eight.sv
// Decode cell: maps one 2-bit packed base code to its ASCII byte.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the input stable while stalled.
// Ports: code (2-bit base code in), ascii (8-bit ASCII byte out).
module TwoBit2Eight
    import genome_pkg::*;
(
    input  logic [1:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_A;
        case (code)
            BASE_A:  ascii = ASCII_A;
            BASE_C:  ascii = ASCII_C;
            BASE_T:  ascii = ASCII_T;
            BASE_G:  ascii = ASCII_G;
            default: ascii = ASCII_A;
        endcase
    end

endmodule

// File: rtl/genome_decode_sequencer.sv
// Streaming decoder: takes a record base count, pulls 2-bit packed words
// (LSB-first) and emits one ASCII base per cycle with a last marker.
// Latency: length handshake -> in_ready next cycle; word handshake -> out_valid
// next cycle; sustained 1 byte/cycle across word boundaries.
// Backpressure: out_ready low freezes out_data/out_last and all state.
// Ports: clk/rst (sync, active-high); len_* length handshake; in_* packed
// word handshake; out_* ASCII byte stream with out_last; done pulse; busy.
module genome_decode_sequencer
    import genome_pkg::*;
#(
    parameter int WORD_W = 32,   // even, >= 4
    parameter int LEN_W  = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  len_data,
    input  logic              len_valid,
    output logic              len_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W / 2 - 1);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [WORD_W-1:0] sr;
    logic [IDX_W-1:0]  idx;
    // Holds len_ready low for the first cycle out of reset even though the
    // state register already reads IDLE.
    logic              len_armed;

    logic [7:0] dec_byte;
    logic       last_base;
    logic       word_end;
    logic       len_fire;
    logic       in_fire;
    logic       out_fire;

    TwoBit2Eight u_decode (
        .code  (sr[1:0]),
        .ascii (dec_byte)
    );

    assign last_base = (remaining == LEN_W'(1));
    assign word_end  = (idx == IDX_LAST);

    // Handshake strobes are gated by rst so a handshake coincident with
    // reset is never seen as consumed by either neighbour.
    assign len_ready = !rst && len_armed && (state == IDLE);
    assign out_valid = !rst && (state == EMIT);
    // Mid-record refill is offered only in the cycle the last slot of the
    // current word is being accepted, so the next word lands with no bubble.
    assign in_ready  = !rst && ((state == LOAD) ||
                       ((state == EMIT) && out_ready && word_end &&
                        (remaining > LEN_W'(1))));

    assign out_data  = out_valid ? dec_byte : 8'h00;
    assign out_last  = out_valid && last_base;
    assign done      = !rst && (state == FIN);
    assign busy      = (state != IDLE);

    assign len_fire  = len_valid && len_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            sr        <= '0;
            idx       <= '0;
            len_armed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (len_fire) begin
                        remaining <= len_data;
                        len_armed <= 1'b0;
                        state     <= (len_data == '0) ? FIN : LOAD;
                    end else begin
                        len_armed <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        sr    <= in_data;
                        idx   <= '0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (remaining != '0)
                            remaining <= remaining - LEN_W'(1);
                        if (last_base) begin
                            // Any unused slots of a final partial word are dropped.
                            sr    <= sr >> 2;
                            idx   <= idx + IDX_W'(1);
                            state <= FIN;
                        end else if (word_end) begin
                            if (in_fire) begin
                                sr  <= in_data;
                                idx <= '0;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            sr  <= sr >> 2;
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    len_armed <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_genome_decode_sequencer.sv
module tb_genome_decode_sequencer;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  len_data;
    logic              len_valid;
    logic              len_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              busy;

    logic [5:0] flags;
    assign flags = {len_ready, in_ready, out_valid, out_last, done, busy};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genome_decode_sequencer #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .len_data  (len_data),
        .len_valid (len_valid),
        .len_ready (len_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy)
    );

    // Advance to just after the next rising edge; inputs are then changed
    // and outputs sampled one more #1 later, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Length handshake then word handshake; leaves the DUT entering EMIT.
    task automatic start_record(input logic [LEN_W-1:0] len, input logic [WORD_W-1:0] w);
        len_data = len; len_valid = 1'b1;
        #1;
        n_checks++;
        if (len_ready !== 1'b1) begin
            n_fail++; $display("FAIL start_len_ready: got %b want 1", len_ready);
        end
        step();
        len_valid = 1'b0; in_data = w; in_valid = 1'b1;
        #1;
        n_checks++;
        if (flags !== 6'b010001) begin
            n_fail++; $display("FAIL start_load_flags: got %b want 010001", flags);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; len_valid = 1'b0; len_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        #1;
        n_checks++;
        if (flags !== 6'b000000 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got flags=%b data=%h want 000000/00", flags, out_data);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (flags !== 6'b100000) begin
            n_fail++; $display("FAIL reset_release: got flags=%b want 100000", flags);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp [4] = '{8'h41, 8'h43, 8'h54, 8'h47};
        int rdy_seen = 1;   // LOAD-cycle in_ready is checked inside start_record
        out_ready = 1'b1;
        start_record(32'd4, 32'h0000_00E4);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_byte%0d: got v=%b d=%h l=%b want 1/%h/%b", k, out_valid, out_data, out_last, exp[k], (k == 3));
            end
            if (in_ready === 1'b1) rdy_seen++;
            step();
        end
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got done=%b v=%b want 1/0", done, out_valid);
        end
        n_checks++;
        if (rdy_seen != 1) begin
            n_fail++; $display("FAIL single_in_ready_count: got %0d want 1", rdy_seen);
        end
        step();
        n_checks++;
        if (flags !== 6'b100000) begin
            n_fail++; $display("FAIL single_idle: got flags=%b want 100000", flags);
        end
    endtask

    task automatic test_word_boundary();
        out_ready = 1'b1;
        start_record(32'd17, 32'h5555_5555);
        for (int k = 0; k < 17; k++) begin
            in_valid = (k <= 15);
            in_data  = 32'h0000_0003;
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ((k == 16) ? 8'h47 : 8'h43) ||
                out_last !== (k == 16) || in_ready !== (k == 15)) begin
                n_fail++;
                $display("FAIL boundary_byte%0d: got v=%b d=%h l=%b ir=%b", k, out_valid, out_data, out_last, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL boundary_done: got done=%b v=%b want 1/0", done, out_valid);
        end
        step();
    endtask

    task automatic test_zero_length();
        len_data = '0; len_valid = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (len_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_len_ready: got %b want 1", len_ready);
        end
        step();
        len_valid = 1'b0;
        #1;
        n_checks++;
        if (flags !== 6'b000011) begin
            n_fail++; $display("FAIL zero_fin: got flags=%b want 000011", flags);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (flags !== 6'b100000) begin
            n_fail++; $display("FAIL zero_idle: got flags=%b want 100000", flags);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4] = '{8'h41, 8'h43, 8'h54, 8'h47};
        logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int nb = 0;
        out_ready = 1'b0;
        start_record(32'd4, 32'h0000_00E4);
        for (int c = 0; c < 7; c++) begin
            out_ready = pat[c];
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp[nb] || out_last !== (nb == 3)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b want 1/%h/%b", c, out_valid, out_data, out_last, exp[nb], (nb == 3));
            end
            if (pat[c]) nb++;
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_done: got done=%b v=%b want 1/0", done, out_valid);
        end
        step();
    endtask

    task automatic test_reset_mid_record();
        out_ready = 1'b1;
        start_record(32'd20, 32'hE4E4_E4E4);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (flags !== 6'b000000 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL midrst_outputs: got flags=%b data=%h want 000000/00", flags, out_data);
        end
        step();
        start_record(32'd1, 32'h0000_0002);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h54 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL midrst_new_byte: got v=%b d=%h l=%b want 1/54/1", out_valid, out_data, out_last);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL midrst_done: got %b want 1", done);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [7:0] tail [2] = '{8'h54, 8'h47};
        out_ready = 1'b1;
        start_record(32'd18, 32'h5555_5555);
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h43 || in_ready !== (k == 15)) begin
                n_fail++; $display("FAIL starve_byte%0d: got v=%b d=%h ir=%b", k, out_valid, out_data, in_ready);
            end
            step();
        end
        for (int g = 0; g < 3; g++) begin
            #1;
            n_checks++;
            if (flags !== 6'b010001) begin
                n_fail++; $display("FAIL starve_gap%0d: got flags=%b want 010001", g, flags);
            end
            step();
        end
        in_data = 32'h0000_000E; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL starve_refill_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== tail[k] || out_last !== (k == 1)) begin
                n_fail++; $display("FAIL starve_tail%0d: got v=%b d=%h l=%b want 1/%h/%b", k, out_valid, out_data, out_last, tail[k], (k == 1));
            end
            step();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL starve_done: got %b want 1", done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_word_boundary();
        test_zero_length();
        test_backpressure();
        test_reset_mid_record();
        test_starvation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
